// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the single bit-slice of the serial datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: a, b, ci -> s (sum bit), co (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock through a single full_adder.
// Latency: done is high WIDTH+1 edges after the start edge (WIDTH RUN cycles, then one DONE cycle).
// Backpressure: none; start is ignored while busy, and is accepted in IDLE or the DONE cycle.
// Ports: clk, rst (sync, active-high), start, a, b, cin in; busy, done, sum, cout out.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_s;
    logic fa_co;

    full_adder u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            // DONE accepts a new start exactly like IDLE so operations can run back-to-back.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
// Latency: expects done WIDTH+1 edges after the start edge.
// Backpressure: drives start only in IDLE/DONE except where start-during-RUN is being exercised.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int errors = 0;
    int checks = 0;
    logic [7:0] last_sum;
    logic       last_cout;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    bit_serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Starts one WIDTH=8 operation and walks it to its DONE cycle. With hold=1, start
    // stays high through RUN with a=0x11 to show it is ignored. Leaves the bench in the DONE cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit hold);
        logic [8:0] exp;
        exp   = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_done_low", {31'd0, done}, 32'd0);
            chk("run_result_hold", {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
            // Operands wander during RUN; they must not leak into the result.
            if (hold) begin
                start = (i < 7);
                a     = 8'h11;
            end else begin
                start = 1'b0;
                a     = 8'($urandom);
            end
            b   = 8'($urandom);
            cin = 1'($urandom);
            tick();
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_not_busy", {31'd0, busy}, 32'd0);
        chk("result", {23'd0, cout, sum}, {23'd0, exp});
        last_sum  = exp[7:0];
        last_cout = exp[8];
    endtask

    task automatic go_idle();
        start = 1'b0;
        tick();
        chk("idle_done_low", {31'd0, done}, 32'd0);
        chk("idle_busy_low", {31'd0, busy}, 32'd0);
        chk("idle_result_hold", {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
    endtask

    initial begin
        logic [4:0] exp4;
        logic       saw_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        last_sum = '0; last_cout = 1'b0;
        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {23'd0, cout, sum}, 32'd0);

        // First start coincides with the first edge that has rst low.
        rst = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        go_idle();

        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        go_idle();
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        go_idle();

        // start held through RUN: one result, one done pulse.
        run_op(8'h22, 8'h33, 1'b0, 1'b1);
        go_idle();

        // Back-to-back: second start issued in the DONE cycle.
        run_op(8'h40, 8'h07, 1'b1, 1'b0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0);
        go_idle();

        // Reset at RUN cycle 4 aborts the operation with no done afterwards.
        a = 8'hC3; b = 8'h5A; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {23'd0, cout, sum}, 32'd0);
        last_sum = '0; last_cout = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            saw_done |= done;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);

        // Random operations, alternating idle gaps and back-to-back starts.
        for (int n = 0; n < 24; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if (n % 3 == 0) go_idle();
        end
        go_idle();

        // Exhaustive WIDTH=4: every (a,b,cin), chained back-to-back through the DONE cycle.
        for (int k = 0; k < 512; k++) begin
            a4     = 4'(k);
            b4     = 4'(k >> 4);
            cin4   = 1'(k >> 8);
            exp4   = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            chk("w4_result", {26'd0, done4, busy4, cout4, sum4}, {26'd0, 1'b1, 1'b0, exp4});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
